// File: rtl/gate_probe_pkg.sv
// Shared types and constants for the gate truth-table prober: FSM states,
// reference truth tables of the standard 2-input gates and their codes.
package gate_probe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Truth tables indexed by {a,b}: bit i is the gate output for input pair i.
  localparam logic [3:0] TT_AND  = 4'h8;
  localparam logic [3:0] TT_OR   = 4'hE;
  localparam logic [3:0] TT_XOR  = 4'h6;
  localparam logic [3:0] TT_NAND = 4'h7;
  localparam logic [3:0] TT_NOR  = 4'h1;
  localparam logic [3:0] TT_XNOR = 4'h9;

  localparam logic [2:0] GC_UNKNOWN = 3'd0;
  localparam logic [2:0] GC_AND     = 3'd1;
  localparam logic [2:0] GC_OR      = 3'd2;
  localparam logic [2:0] GC_XOR     = 3'd3;
  localparam logic [2:0] GC_NAND    = 3'd4;
  localparam logic [2:0] GC_NOR     = 3'd5;
  localparam logic [2:0] GC_XNOR    = 3'd6;

  // Step k drives {a,b} = {k[1], k[1]^k[0]}: a Gray walk 00, 01, 11, 10.
  function automatic logic [1:0] step_stim(input logic [1:0] step);
    return {step[1], step[1] ^ step[0]};
  endfunction

endpackage

// File: rtl/gate_truth_table_prober_if.sv
// Control/result bundle of the gate truth-table prober.
// gate_code is present only when GATE_CLASSIFY_EN is defined.
interface gate_truth_table_prober_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] truth_table;
`ifdef GATE_CLASSIFY_EN
  logic [2:0] gate_code;

  modport master (output start, input busy, input done, input truth_table, input gate_code);
  modport slave  (input start, output busy, output done, output truth_table, output gate_code);
`else
  modport master (output start, input busy, input done, input truth_table);
  modport slave  (input start, output busy, output done, output truth_table);
`endif
endinterface

// File: rtl/gate_classifier.sv
// Combinational lookup from a 2-input truth table to a standard gate code;
// anything that is not one of the six known gates reports UNKNOWN.
module gate_classifier
  import gate_probe_pkg::*;
(
  input  logic [3:0] tt,
  output logic [2:0] code
);

  always_comb begin
    code = GC_UNKNOWN;
    case (tt)
      TT_AND:  code = GC_AND;
      TT_OR:   code = GC_OR;
      TT_XOR:  code = GC_XOR;
      TT_NAND: code = GC_NAND;
      TT_NOR:  code = GC_NOR;
      TT_XNOR: code = GC_XNOR;
      default: code = GC_UNKNOWN;
    endcase
  end

endmodule

// File: rtl/gate_truth_table_prober.sv
// Walks a 2-input combinational cell through 00,01,11,10 and captures its truth table.
// Optional gate classification output is enabled by defining GATE_CLASSIFY_EN.
module gate_truth_table_prober
  import gate_probe_pkg::*;
#(
  parameter int HOLD_CYCLES = 20
)
(
  input  logic                       clk,
  input  logic                       areset_n,
  gate_truth_table_prober_if.slave   ctrl,
  output logic                       stim_a,
  output logic                       stim_b,
  input  logic                       dut_out
);

  localparam int               CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state, state_nxt;
  logic [1:0]       step, step_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       stim_nxt;
  logic             busy, busy_nxt;
  logic             done, done_nxt;
  logic [3:0]       shadow, shadow_nxt;
  logic [3:0]       tt, tt_nxt;

  always_comb begin
    state_nxt  = state;
    step_nxt   = step;
    cnt_nxt    = cnt;
    stim_nxt   = {stim_a, stim_b};
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    shadow_nxt = shadow;
    tt_nxt     = tt;
    case (state)
      IDLE: begin
        if (ctrl.start) begin
          state_nxt = DRIVE;
          step_nxt  = 2'd0;
          cnt_nxt   = '0;
          stim_nxt  = 2'b00;
          busy_nxt  = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          // Sample at the last cycle of the hold; the cell is combinational,
          // so even a one-cycle hold sees a settled output here.
          shadow_nxt[{stim_a, stim_b}] = dut_out;
          cnt_nxt = '0;
          if (step == 2'd3) begin
            state_nxt = DONE;
            tt_nxt    = shadow_nxt;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            stim_nxt  = 2'b00;
          end else begin
            step_nxt = step + 2'd1;
            stim_nxt = step_stim(step + 2'd1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state  <= IDLE;
      step   <= 2'd0;
      cnt    <= '0;
      stim_a <= 1'b0;
      stim_b <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      shadow <= 4'h0;
      tt     <= 4'h0;
    end else begin
      state  <= state_nxt;
      step   <= step_nxt;
      cnt    <= cnt_nxt;
      stim_a <= stim_nxt[1];
      stim_b <= stim_nxt[0];
      busy   <= busy_nxt;
      done   <= done_nxt;
      shadow <= shadow_nxt;
      tt     <= tt_nxt;
    end
  end

  assign ctrl.busy        = busy;
  assign ctrl.done        = done;
  assign ctrl.truth_table = tt;

`ifdef GATE_CLASSIFY_EN
  logic [2:0] code_nxt;
  logic [2:0] gate_code;

  gate_classifier u_classifier (
    .tt   (tt_nxt),
    .code (code_nxt)
  );

  // Updated together with truth_table so the two never disagree.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      gate_code <= GC_UNKNOWN;
    end else if (done_nxt) begin
      gate_code <= code_nxt;
    end
  end

  assign ctrl.gate_code = gate_code;
`endif

endmodule

// File: tb/tb_gate_truth_table_prober.sv
// Self-checking bench for gate_truth_table_prober: two instances (hold 20 and
// hold 1) probing behavioural gate models, with a queue of expected tables.
module tb_gate_truth_table_prober;

  localparam int H_A = 20;
  localparam int H_B = 1;

  localparam int G_AND = 0;
  localparam int G_XOR = 1;
  localparam int G_ONE = 2;
  localparam int G_NOR = 3;

  logic clk;
  logic areset_n;
  logic stim_a_a, stim_b_a, dut_out_a;
  logic stim_a_b, stim_b_b, dut_out_b;
  int   gate_a, gate_b;

  int checks   = 0;
  int failures = 0;

  logic [3:0] last_tt_a;
  logic [3:0] exp_tt_q[$];
  logic [2:0] exp_gc_q[$];
  logic [3:0] exp_tt_qb[$];
  logic [2:0] exp_gc_qb[$];

  gate_truth_table_prober_if ctrl_a ();
  gate_truth_table_prober_if ctrl_b ();

  function automatic logic gate_fn(input int g, input logic a, input logic b);
    case (g)
      G_AND:   return a & b;
      G_XOR:   return a ^ b;
      G_ONE:   return 1'b1;
      default: return ~(a | b);
    endcase
  endfunction

  assign dut_out_a = gate_fn(gate_a, stim_a_a, stim_b_a);
  assign dut_out_b = gate_fn(gate_b, stim_a_b, stim_b_b);

  gate_truth_table_prober #(.HOLD_CYCLES(H_A)) u_dut_a (
    .clk      (clk),
    .areset_n (areset_n),
    .ctrl     (ctrl_a),
    .stim_a   (stim_a_a),
    .stim_b   (stim_b_a),
    .dut_out  (dut_out_a)
  );

  gate_truth_table_prober #(.HOLD_CYCLES(H_B)) u_dut_b (
    .clk      (clk),
    .areset_n (areset_n),
    .ctrl     (ctrl_b),
    .stim_a   (stim_a_b),
    .stim_b   (stim_b_b),
    .dut_out  (dut_out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full run on instance A; optional extra start pulse at cycle mid_j.
  task automatic run_a(input logic [3:0] exp_tt, input logic [2:0] exp_gc, input int mid_j);
    logic [3:0] pop_tt;
    logic [2:0] pop_gc;
    int k;
    @(negedge clk);
    ctrl_a.start = 1'b1;
    exp_tt_q.push_back(exp_tt);
    exp_gc_q.push_back(exp_gc);
    @(negedge clk);
    ctrl_a.start = 1'b0;
    for (int j = 0; j < 4 * H_A; j++) begin
      k = j / H_A;
      checks++;
      if (stim_a_a !== k[1] || stim_b_a !== (k[1] ^ k[0])) begin
        failures++;
        $display("FAIL stim_seq j=%0d got=%b%b want=%b%b", j, stim_a_a, stim_b_a, k[1], k[1] ^ k[0]);
      end
      checks++;
      if (ctrl_a.busy !== 1'b1 || ctrl_a.done !== 1'b0) begin
        failures++;
        $display("FAIL busy_during_run j=%0d got busy=%b done=%b want busy=1 done=0", j, ctrl_a.busy, ctrl_a.done);
      end
      checks++;
      if (ctrl_a.truth_table !== last_tt_a) begin
        failures++;
        $display("FAIL tt_held j=%0d got=%h want=%h", j, ctrl_a.truth_table, last_tt_a);
      end
      ctrl_a.start = (j == mid_j);
      @(negedge clk);
    end
    ctrl_a.start = 1'b0;
    pop_tt = exp_tt_q.pop_front();
    pop_gc = exp_gc_q.pop_front();
    checks++;
    if (ctrl_a.done !== 1'b1 || ctrl_a.busy !== 1'b0) begin
      failures++;
      $display("FAIL done_latency got done=%b busy=%b want done=1 busy=0", ctrl_a.done, ctrl_a.busy);
    end
    checks++;
    if (ctrl_a.truth_table !== pop_tt) begin
      failures++;
      $display("FAIL truth_table got=%h want=%h", ctrl_a.truth_table, pop_tt);
    end
    checks++;
    if (stim_a_a !== 1'b0 || stim_b_a !== 1'b0) begin
      failures++;
      $display("FAIL stim_in_done got=%b%b want=00", stim_a_a, stim_b_a);
    end
`ifdef GATE_CLASSIFY_EN
    checks++;
    if (ctrl_a.gate_code !== pop_gc) begin
      failures++;
      $display("FAIL gate_code got=%0d want=%0d", ctrl_a.gate_code, pop_gc);
    end
`endif
    last_tt_a = pop_tt;
    @(negedge clk);
    checks++;
    if (ctrl_a.done !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle got=%b want=0", ctrl_a.done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (ctrl_a.busy !== 1'b0 || ctrl_a.done !== 1'b0 || ctrl_a.truth_table !== 4'h0) begin
      failures++;
      $display("FAIL reset_ctrl got busy=%b done=%b tt=%h want 0 0 0", ctrl_a.busy, ctrl_a.done, ctrl_a.truth_table);
    end
    checks++;
    if (stim_a_a !== 1'b0 || stim_b_a !== 1'b0 || stim_a_b !== 1'b0 || stim_b_b !== 1'b0) begin
      failures++;
      $display("FAIL reset_stim got=%b%b %b%b want=00 00", stim_a_a, stim_b_a, stim_a_b, stim_b_b);
    end
`ifdef GATE_CLASSIFY_EN
    checks++;
    if (ctrl_a.gate_code !== 3'd0) begin
      failures++;
      $display("FAIL reset_gate_code got=%0d want=0", ctrl_a.gate_code);
    end
`endif
    areset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl_a.busy !== 1'b0 || ctrl_b.busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b/%b want 0/0", ctrl_a.busy, ctrl_b.busy);
    end
  endtask

  task automatic test_and_h20();
    gate_a = G_AND;
    run_a(4'h8, 3'd1, -1);
  endtask

  task automatic test_hold1_xor();
    logic [3:0] pop_tt;
    logic [2:0] pop_gc;
    logic [1:0] k;
    gate_b = G_XOR;
    @(negedge clk);
    ctrl_b.start = 1'b1;
    exp_tt_qb.push_back(4'h6);
    exp_gc_qb.push_back(3'd3);
    @(negedge clk);
    ctrl_b.start = 1'b0;
    for (int j = 0; j < 4 * H_B; j++) begin
      k = 2'(j);
      checks++;
      if (stim_a_b !== k[1] || stim_b_b !== (k[1] ^ k[0]) || ctrl_b.busy !== 1'b1) begin
        failures++;
        $display("FAIL h1_stim j=%0d got=%b%b busy=%b want=%b%b busy=1", j, stim_a_b, stim_b_b, ctrl_b.busy, k[1], k[1] ^ k[0]);
      end
      @(negedge clk);
    end
    pop_tt = exp_tt_qb.pop_front();
    pop_gc = exp_gc_qb.pop_front();
    checks++;
    if (ctrl_b.done !== 1'b1 || ctrl_b.truth_table !== pop_tt) begin
      failures++;
      $display("FAIL h1_done got done=%b tt=%h want done=1 tt=%h", ctrl_b.done, ctrl_b.truth_table, pop_tt);
    end
    checks++;
    if (stim_a_b !== 1'b0 || stim_b_b !== 1'b0) begin
      failures++;
      $display("FAIL h1_stim_done got=%b%b want=00", stim_a_b, stim_b_b);
    end
`ifdef GATE_CLASSIFY_EN
    checks++;
    if (ctrl_b.gate_code !== pop_gc) begin
      failures++;
      $display("FAIL h1_gate_code got=%0d want=%0d", ctrl_b.gate_code, pop_gc);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_const_then_nor();
    gate_a = G_ONE;
    run_a(4'hF, 3'd0, -1);
    gate_a = G_NOR;
    run_a(4'h1, 3'd5, -1);
  endtask

  task automatic test_mid_start();
    gate_a = G_AND;
    run_a(4'h8, 3'd1, 2 * H_A + 5);
    for (int i = 0; i < 2 * H_A; i++) begin
      checks++;
      if (ctrl_a.done !== 1'b0 || ctrl_a.busy !== 1'b0) begin
        failures++;
        $display("FAIL mid_start_ignored i=%0d got done=%b busy=%b want 0 0", i, ctrl_a.done, ctrl_a.busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    gate_a = G_AND;
    @(negedge clk);
    ctrl_a.start = 1'b1;
    exp_tt_q.push_back(4'h8);
    exp_gc_q.push_back(3'd1);
    @(negedge clk);
    ctrl_a.start = 1'b0;
    repeat (H_A + 5) @(negedge clk);
    checks++;
    if (ctrl_a.busy !== 1'b1 || stim_a_a !== 1'b0 || stim_b_a !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort got busy=%b stim=%b%b want busy=1 stim=01", ctrl_a.busy, stim_a_a, stim_b_a);
    end
    #2 areset_n = 1'b0;
    #1;
    exp_tt_q.delete();
    exp_gc_q.delete();
    checks++;
    if (ctrl_a.busy !== 1'b0 || ctrl_a.done !== 1'b0 || ctrl_a.truth_table !== 4'h0 ||
        stim_a_a !== 1'b0 || stim_b_a !== 1'b0) begin
      failures++;
      $display("FAIL async_abort got busy=%b done=%b tt=%h stim=%b%b want all 0",
               ctrl_a.busy, ctrl_a.done, ctrl_a.truth_table, stim_a_a, stim_b_a);
    end
`ifdef GATE_CLASSIFY_EN
    checks++;
    if (ctrl_a.gate_code !== 3'd0) begin
      failures++;
      $display("FAIL abort_gate_code got=%0d want=0", ctrl_a.gate_code);
    end
`endif
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (ctrl_a.done !== 1'b0) begin
        failures++;
        $display("FAIL abort_no_done got=%b want=0", ctrl_a.done);
      end
    end
    areset_n = 1'b1;
    last_tt_a = 4'h0;
    run_a(4'h8, 3'd1, -1);
  endtask

  task automatic test_back_to_back();
    int cyc;
    int ndone;
    int t[3];
    logic [3:0] pop_tt;
    logic [2:0] pop_gc;
    gate_a = G_XOR;
    @(negedge clk);
    ctrl_a.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_tt_q.push_back(4'h6);
      exp_gc_q.push_back(3'd3);
    end
    cyc = 0;
    ndone = 0;
    while (ndone < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (ctrl_a.done === 1'b1) begin
        t[ndone] = cyc;
        pop_tt = exp_tt_q.pop_front();
        pop_gc = exp_gc_q.pop_front();
        checks++;
        if (ctrl_a.truth_table !== pop_tt) begin
          failures++;
          $display("FAIL b2b_tt run=%0d got=%h want=%h", ndone, ctrl_a.truth_table, pop_tt);
        end
`ifdef GATE_CLASSIFY_EN
        checks++;
        if (ctrl_a.gate_code !== pop_gc) begin
          failures++;
          $display("FAIL b2b_gate_code run=%0d got=%0d want=%0d", ndone, ctrl_a.gate_code, pop_gc);
        end
`endif
        ndone++;
      end
    end
    ctrl_a.start = 1'b0;
    checks++;
    if (ndone != 3) begin
      failures++;
      $display("FAIL b2b_timeout got %0d done pulses in %0d cycles want 3", ndone, cyc);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (t[i] - t[i-1] != 4 * H_A + 2) begin
          failures++;
          $display("FAIL b2b_spacing run=%0d got=%0d want=%0d", i, t[i] - t[i-1], 4 * H_A + 2);
        end
      end
    end
    repeat (3) @(negedge clk);
    last_tt_a = 4'h6;
    checks++;
    if (ctrl_a.busy !== 1'b0 || ctrl_a.truth_table !== last_tt_a) begin
      failures++;
      $display("FAIL b2b_stop got busy=%b tt=%h want busy=0 tt=%h", ctrl_a.busy, ctrl_a.truth_table, last_tt_a);
    end
  endtask

  initial begin
    areset_n     = 1'b0;
    ctrl_a.start = 1'b0;
    ctrl_b.start = 1'b0;
    gate_a       = G_AND;
    gate_b       = G_XOR;
    last_tt_a    = 4'h0;
    test_reset();
    test_and_h20();
    test_hold1_xor();
    test_const_then_nor();
    test_mid_start();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_truth_table_prober.md
Name: gate_truth_table_prober

Overview:
- Synthesizable stimulus-and-capture engine for any 2-input, 1-output combinational DUT.
- Drives the DUT inputs through the fixed sequence 00, 01, 11, 10, holding each pair for a programmable number of cycles.
- Samples the DUT output at the end of each hold and assembles a 4-bit truth table.
- Hardware counterpart of the team's bench stimulus flow, for on-chip self-test of small logic cells.

Parameters:
- HOLD_CYCLES, 20, clock cycles each input pair is held; legal range >= 1.
- CNT_W, $clog2(HOLD_CYCLES+1) (localparam), width of the hold counter.

Ports:
- clk  input  1  rising-edge clock
- areset_n  input  1  asynchronous active-low reset
- start  input  1  run request; sampled only in IDLE
- stim_a  output  1  drives DUT in_1
- stim_b  output  1  drives DUT in_2
- dut_out  input  1  DUT out_1, combinational from stim_a/stim_b
- busy  output  1  high while sequencing
- done  output  1  one-cycle pulse when truth_table is updated
- truth_table  output  4  bit index {a,b}; bit[i] = DUT output for input pair i
- gate_code  output  3  only when GATE_CLASSIFY_EN is defined

Behaviour:
- Reset (asynchronous, areset_n=0): state=IDLE, step=0, cnt=0, stim_a=stim_b=0, busy=0, done=0, truth_table=0, gate_code=0, shadow register=0.
- FSM states: IDLE, DRIVE, DONE.
- IDLE -> DRIVE on an edge where start=1. At that edge: step=0, cnt=0, stim=00, busy=1.
- DRIVE sequence:
  - step k in 0..3 maps to stim_a=k[1], stim_b=k[1]^k[0], giving 00, 01, 11, 10.
  - Each step lasts exactly HOLD_CYCLES cycles.
  - While cnt<HOLD_CYCLES-1, cnt increments each cycle.
  - At the edge where cnt==HOLD_CYCLES-1, dut_out is captured into shadow[{stim_a,stim_b}] and cnt clears.
  - If step<3, step increments. If step==3, the FSM goes to DONE.
- DONE (exactly one cycle):
  - truth_table<=shadow, committed atomically at DONE entry; done=1; busy=0; stim=00.
  - Next edge -> IDLE unconditionally.
- Latency: done is high in the cycle 4*HOLD_CYCLES cycles after busy rises.
- HOLD_CYCLES=1: each pair lasts one cycle and is sampled in that same cycle. This is legal because the DUT is combinational.
- start while busy or in DONE is ignored; no queuing. start held high across DONE re-triggers from IDLE on the following edge.
- truth_table holds its last committed value through later runs until the next DONE. A partial run never changes it.
- Reset mid-run aborts immediately with reset values, truth_table included. No done pulse.
- stim_a and stim_b are registered outputs, glitch-free, and change only at step boundaries.

Optional Feature:
- Macro GATE_CLASSIFY_EN.
- Defined: gate_code port exists and is registered at DONE entry from the committed truth table. Codes:
  - 0x8 -> 1 AND
  - 0xE -> 2 OR
  - 0x6 -> 3 XOR
  - 0x7 -> 4 NAND
  - 0x1 -> 5 NOR
  - 0x9 -> 6 XNOR
  - any other value -> 0 UNKNOWN
- gate_code holds its value until the next DONE.
- Undefined: no gate_code port and no classification logic; all other behaviour is identical.

Decomposition:
- Package gate_probe_pkg holds:
  - state enum {IDLE, DRIVE, DONE}
  - truth-table constants TT_AND, TT_OR, TT_XOR, TT_NAND, TT_NOR, TT_XNOR
  - gate code constants GC_UNKNOWN..GC_XNOR
- Sub-module gate_classifier: purely combinational 4-bit to 3-bit lookup, instantiated only under GATE_CLASSIFY_EN.
- Sequencer, counter and capture logic stay in the top block.

Test Plan:
- AND DUT, HOLD_CYCLES=20, start pulse -> stim 00/01/11/10 for 20 cycles each; done pulse 80 cycles after busy rises; truth_table=0x8; gate_code=1.
- XOR DUT, HOLD_CYCLES=1 -> done 4 cycles after busy; truth_table=0x6; gate_code=3; stim returns to 00 in DONE.
- Constant-1 DUT -> truth_table=0xF, gate_code=0. A second run on a NOR DUT changes truth_table 0xF->0x1 only at its done pulse.
- start pulsed again mid-run (step 2) -> ignored; sequence timing unchanged; exactly one done.
- areset_n low at step 1, cycle 5 -> all outputs go to 0 immediately (asynchronously), no done. Later start runs a clean full sequence.
- start held high continuously -> back-to-back runs: DONE, IDLE, then DRIVE again; done pulses exactly 4*HOLD_CYCLES+2 cycles apart.
